// File: rtl/brlite_pkg.sv
// Shared BrLite types: flit format, local-arbiter FSM states, statistics width.
// No logic; imported by the router-side blocks.
package BrLitePkg;

    localparam int BR_ARB_CNT_W = 16;

    typedef struct packed {
        logic [7:0]  src;
        logic [3:0]  svc;
        logic [15:0] payload;
    } br_data_t;

    typedef enum logic [2:0] {
        BR_ARB_IDLE,
        BR_ARB_GRANT,
        BR_ARB_REQ,
        BR_ARB_RELEASE,
        BR_ARB_WAIT_BUSY
    } br_arb_state_t;

endpackage

// File: rtl/brlite_rr_picker.sv
// Round-robin picker: first requesting index strictly above last_i, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; vld_o is low when no request is present.
module brlite_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 vld_o
);

    localparam int IW = $clog2(N);

    always_comb begin
        int cand;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = 0;
        // Scan starts one past the last winner so that index ends up lowest priority.
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last_i) + i) % N;
            if (!vld_o && req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/brlite_local_arbiter.sv
// Round-robin injection arbiter in front of the router BR_LOCAL input port.
// Latency: request to req_o in 2 cycles best case; src_ack_o the cycle after ack_i.
// Backpressure: holds req_o until ack_i; no new grant while local_busy_i is high.
// Optional per-source grant counters under BRLITE_ARB_STATS_EN.
module brlite_local_arbiter
    import BrLitePkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_SRC-1:0]           src_req_i,
    input  br_data_t [N_SRC-1:0]       src_flit_i,
    output logic [N_SRC-1:0]           src_ack_o,
    output br_data_t                   flit_o,
    output logic                       req_o,
    input  logic                       ack_i,
    input  logic                       local_busy_i,
    output logic [$clog2(N_SRC)-1:0]   grant_o,
    output logic                       busy_o
`ifdef BRLITE_ARB_STATS_EN
    ,
    output logic [N_SRC-1:0][BR_ARB_CNT_W-1:0] grant_cnt_o
`endif
);

    localparam int                IDX_W    = $clog2(N_SRC);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_SRC - 1);

    br_arb_state_t    state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] pick_q, pick_d;
    br_data_t         flit_q, flit_d;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_vld;

`ifdef BRLITE_ARB_STATS_EN
    logic [N_SRC-1:0][BR_ARB_CNT_W-1:0] cnt_q, cnt_d;
`endif

    brlite_rr_picker #(
        .N (N_SRC)
    ) u_picker (
        .req_i  (src_req_i),
        .last_i (grant_q),
        .idx_o  (rr_idx),
        .vld_o  (rr_vld)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        pick_d  = pick_q;
        flit_d  = flit_q;
`ifdef BRLITE_ARB_STATS_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            BR_ARB_IDLE: begin
                if (rr_vld && !local_busy_i) begin
                    pick_d  = rr_idx;
                    state_d = BR_ARB_GRANT;
                end
            end
            BR_ARB_GRANT: begin
                // A withdrawn request abandons the pick without moving the round-robin pointer.
                if (src_req_i[pick_q]) begin
                    grant_d = pick_q;
                    flit_d  = src_flit_i[pick_q];
                    state_d = BR_ARB_REQ;
                end else begin
                    state_d = BR_ARB_IDLE;
                end
            end
            BR_ARB_REQ: begin
                if (ack_i) begin
                    state_d = BR_ARB_RELEASE;
`ifdef BRLITE_ARB_STATS_EN
                    if (cnt_q[grant_q] != '1) begin
                        cnt_d[grant_q] = cnt_q[grant_q] + BR_ARB_CNT_W'(1);
                    end
`endif
                end
            end
            BR_ARB_RELEASE: begin
                if (!ack_i && !src_req_i[grant_q]) begin
                    state_d = BR_ARB_WAIT_BUSY;
                end
            end
            BR_ARB_WAIT_BUSY: begin
                if (!local_busy_i) begin
                    state_d = BR_ARB_IDLE;
                end
            end
            default: state_d = BR_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BR_ARB_IDLE;
            grant_q <= LAST_IDX;
            pick_q  <= LAST_IDX;
            flit_q  <= '0;
`ifdef BRLITE_ARB_STATS_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pick_q  <= pick_d;
            flit_q  <= flit_d;
`ifdef BRLITE_ARB_STATS_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        src_ack_o = '0;
        if (state_q == BR_ARB_RELEASE) begin
            src_ack_o[grant_q] = 1'b1;
        end
    end

    // Outputs come from registers only, so a source flit never reaches the router combinationally.
    assign req_o   = (state_q == BR_ARB_REQ);
    assign busy_o  = (state_q != BR_ARB_IDLE);
    assign flit_o  = flit_q;
    assign grant_o = grant_q;

`ifdef BRLITE_ARB_STATS_EN
    assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_brlite_local_arbiter.sv
// Bench for brlite_local_arbiter: directed scenarios plus random traffic,
// checked against a round-robin reference model and a simple router model.
module tb_brlite_local_arbiter;
    import BrLitePkg::*;

    localparam int N = 4;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b1;
    logic [N-1:0]       src_req = '0;
    br_data_t [N-1:0]   src_flit = '0;
    logic [N-1:0]       src_ack;
    br_data_t           flit;
    logic               req;
    logic               ack;
    logic               local_busy;
    logic [1:0]         grant;
    logic               busy;
`ifdef BRLITE_ARB_STATS_EN
    logic [N-1:0][15:0] grant_cnt;
`endif

    brlite_local_arbiter #(.N_SRC(N)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .src_req_i    (src_req),
        .src_flit_i   (src_flit),
        .src_ack_o    (src_ack),
        .flit_o       (flit),
        .req_o        (req),
        .ack_i        (ack),
        .local_busy_i (local_busy),
        .grant_o      (grant),
        .busy_o       (busy)
`ifdef BRLITE_ARB_STATS_EN
        ,
        .grant_cnt_o  (grant_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic br_data_t rand_flit();
        br_data_t f;
        f.src     = 8'($urandom);
        f.svc     = 4'($urandom);
        f.payload = 16'($urandom);
        return f;
    endfunction

    function automatic int rr_next(input logic [N-1:0] vec, input int last);
        for (int i = 1; i <= N; i++) begin
            if (vec[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Router model: acks ack_delay cycles after req, raises local busy for busy_len cycles.
    int ack_delay = 4;
    int busy_len = 10;
    int ack_wait = 0;
    int busy_left = 0;
    bit rand_router = 0;

    initial begin
        ack = 1'b0;
        local_busy = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                ack = 1'b0; local_busy = 1'b0; ack_wait = 0; busy_left = 0;
            end else begin
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) local_busy = 1'b0;
                end
                if (req && !ack) begin
                    if (ack_wait >= ack_delay) begin
                        ack = 1'b1;
                        ack_wait = 0;
                        if (busy_len > 0) begin
                            local_busy = 1'b1;
                            busy_left = busy_len;
                        end
                    end else begin
                        ack_wait++;
                    end
                end else if (!req && ack) begin
                    ack = 1'b0;
                    if (rand_router) begin
                        ack_delay = 4 + $urandom_range(4);
                        busy_len = $urandom_range(12);
                    end
                end
            end
        end
    end

    // Source models: mode 0 manual, 1 re-request at once, 2 random think time.
    int src_mode = 0;
    int want[N];

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (src_mode != 0 && rst_ni) begin
                for (int i = 0; i < N; i++) begin
                    if (src_req[i] && src_ack[i]) begin
                        src_req[i] = 1'b0;
                    end else if (!src_req[i] && !src_ack[i] && want[i] > 0 &&
                                 (src_mode == 1 || $urandom_range(3) == 0)) begin
                        src_flit[i] = rand_flit();
                        src_req[i] = 1'b1;
                        want[i]--;
                    end
                end
            end
        end
    end

    // Reference monitor: predicts the winner from the request set seen while idle.
    int p_last = N - 1;
    int pred = 0;
    int cyc = 0;
    int grants[$];
    int model_cnt[N];
    logic [N-1:0] p_req = '0;
    logic p_busy = 1'b0, p_lbusy = 1'b0, p_reqo = 1'b0, p_acki = 1'b0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            p_last = N - 1;
            for (int i = 0; i < N; i++) model_cnt[i] = 0;
        end else begin
            if (busy && !p_busy) begin
                check_eq("mon_no_grant_while_local_busy", p_lbusy, 1'b0);
                pred = rr_next(p_req, p_last);
                cyc = 0;
            end
            if (req && !p_reqo) begin
                check_eq("mon_grant_idx", grant, pred);
                check_eq("mon_flit", flit, src_flit[pred]);
                check_eq("mon_req_latency", cyc, 1);
            end
            if (p_reqo && p_acki) begin
                check_eq("mon_src_ack", src_ack, 64'(1) << pred);
                p_last = pred;
                grants.push_back(pred);
                model_cnt[pred]++;
            end
            cyc++;
        end
        p_busy = busy; p_lbusy = local_busy; p_reqo = req; p_acki = ack; p_req = src_req;
    end

    task automatic do_reset(input string tag);
        rst_ni = 1'b0;
        src_req = '0;
        #2;
        check_eq({tag, "_req"}, req, 1'b0);
        check_eq({tag, "_src_ack"}, src_ack, '0);
        check_eq({tag, "_flit"}, flit, '0);
        check_eq({tag, "_grant"}, grant, N - 1);
        check_eq({tag, "_busy"}, busy, 1'b0);
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || local_busy || src_ack != '0 || ack) && n < 2000) begin
            tick();
            n++;
        end
        check_eq({tag, "_idle"}, n < 2000, 1'b1);
    endtask

    task automatic wait_ack(input int s, input string tag);
        int n = 0;
        while (!src_ack[s] && n < 1000) begin
            tick();
            n++;
        end
        check_eq({tag, "_ack_seen"}, n < 1000, 1'b1);
    endtask

    initial begin
        int n, n2, bad_req, bad_flit, idle;
        br_data_t held;

        #1;
        do_reset("rst0");

        // Single source with payload 0xA5, ack after 4, busy 10.
        ack_delay = 4; busy_len = 10;
        src_flit[2] = rand_flit();
        src_flit[2].payload = 16'h00A5;
        src_req[2] = 1'b1;
        n = 0;
        while (!req && n < 100) begin tick(); n++; end
        check_eq("t1_req_latency", n, 2);
        check_eq("t1_payload", flit.payload, 16'h00A5);
        wait_ack(2, "t1");
        check_eq("t1_src_ack", src_ack, 4'b0100);
        src_req[2] = 1'b0;
        src_flit[0] = rand_flit();
        src_req[0] = 1'b1;
        n = 0; bad_req = 0;
        while (local_busy && n < 100) begin
            if (req) bad_req++;
            tick();
            n++;
        end
        check_eq("t1_hold_off", bad_req, 0);
        n2 = 0;
        while (!req && n2 < 100) begin tick(); n2++; end
        check_eq("t1_regrant_delay", n2, 3);
        wait_ack(0, "t1b");
        src_req[0] = 1'b0;
        wait_idle("t1");

        // All four requesting continuously: order 0,1,2,3,0.
        do_reset("rst1");
        busy_len = 3;
        grants.delete();
        for (int i = 0; i < N; i++) want[i] = 5;
        src_mode = 1;
        n = 0;
        while (grants.size() < 5 && n < 3000) begin tick(); n++; end
        check_eq("t2_grants_seen", grants.size() >= 5, 1'b1);
        for (int k = 0; k < 5 && k < grants.size(); k++) begin
            check_eq($sformatf("t2_order%0d", k), grants[k], k % N);
        end
        for (int i = 0; i < N; i++) want[i] = 0;
        n = 0;
        while (src_req != '0 && n < 3000) begin tick(); n++; end
        src_mode = 0;
        wait_idle("t2");

        // Router CAM full: ack withheld 50 cycles.
        ack_delay = 50; busy_len = 2;
        src_flit[1] = rand_flit();
        src_req[1] = 1'b1;
        n = 0;
        while (!req && n < 100) begin tick(); n++; end
        held = flit;
        bad_req = 0; bad_flit = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (!req) bad_req++;
            if (flit !== held) bad_flit++;
        end
        check_eq("t3_req_held", bad_req, 0);
        check_eq("t3_flit_stable", bad_flit, 0);
        wait_ack(1, "t3");
        src_req[1] = 1'b0;
        wait_idle("t3");

        // Duplicate flit: no busy, next source follows after a single idle cycle.
        ack_delay = 4; busy_len = 0;
        src_flit[2] = rand_flit(); src_flit[3] = rand_flit();
        src_req[2] = 1'b1; src_req[3] = 1'b1;
        wait_ack(2, "t4");
        src_req[2] = 1'b0;
        n = 0; idle = 0;
        while (!req && n < 100) begin
            tick();
            n++;
            if (!busy) idle++;
        end
        check_eq("t4_idle_gap", idle, 1);
        check_eq("t4_next_grant", grant, 3);
        wait_ack(3, "t4b");
        src_req[3] = 1'b0;
        wait_idle("t4");

        // Reset asserted while in REQ.
        ack_delay = 50; busy_len = 5;
        src_flit[2] = rand_flit();
        src_req[2] = 1'b1;
        n = 0;
        while (!req && n < 100) begin tick(); n++; end
        tick();
        rst_ni = 1'b0;
        #1;
        check_eq("t5_req_async", req, 1'b0);
        check_eq("t5_src_ack_async", src_ack, '0);
        check_eq("t5_busy_async", busy, 1'b0);
        check_eq("t5_grant_async", grant, N - 1);
        src_flit[0] = rand_flit();
        src_req[0] = 1'b1;
        ack_delay = 4;
        tick(); tick();
        rst_ni = 1'b1;
        n = 0;
        while (!req && n < 100) begin tick(); n++; end
        check_eq("t5_first_grant", grant, 0);
        wait_ack(0, "t5a");
        src_req[0] = 1'b0;
        wait_ack(2, "t5b");
        src_req[2] = 1'b0;
        wait_idle("t5");

        // Random traffic with a randomised router.
        grants.delete();
        rand_router = 1;
        for (int i = 0; i < N; i++) want[i] = 10;
        src_mode = 2;
        n = 0;
        while ((want[0] + want[1] + want[2] + want[3] > 0 || src_req != '0) && n < 20000) begin
            tick();
            n++;
        end
        src_mode = 0;
        wait_idle("t6");
        check_eq("t6_grant_total", grants.size(), 40);

`ifdef BRLITE_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("stats_cnt%0d", i), grant_cnt[i], model_cnt[i]);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
